// File: rtl/pc_fetch_ctrl.sv
// PC register, branch/jump redirect and instruction-fetch handshake for the IF stage.
// Optional branch statistics counters are built when BR_STATS_EN is defined.
module pc_fetch_ctrl #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        id_valid,
  input  logic        is_beq,
  input  logic        is_bne,
  input  logic        is_j,
  input  logic        is_jr,
  input  logic        equal,
  input  logic [31:0] pc_id,
  input  logic [15:0] imm16,
  input  logic [25:0] instr_index,
  input  logic [31:0] rs_val,
  input  logic        imem_ack,
  output logic [31:0] pc,
  output logic        imem_req,
  output logic        fetch_valid,
  output logic [31:0] link_pc,
`ifdef BR_STATS_EN
  output logic [31:0] br_cnt,
  output logic [31:0] br_taken_cnt,
`endif
  output logic        state_dbg,
  output logic        pend_dbg
);

  typedef enum logic {
    FETCH      = 1'b0,
    FETCH_PEND = 1'b1
  } state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic        req_q;
  logic        pend_q;
  logic [31:0] pend_target_q;

  logic        taken;
  logic        redir_now;
  logic [31:0] pc_id_plus4;
  logic [31:0] br_offset;
  logic [31:0] br_target;
  logic [31:0] j_target;
  logic [31:0] target;
  logic [31:0] pc_seq;

  // Handshake: imem_req stays high once out of reset; imem_ack in a cycle means the
  // word at pc is delivered that cycle (fetch_valid). The pc moves on at that edge
  // unless stall holds it, in which case the same address is fetched again.

  assign taken = id_valid && ((is_beq && equal) || (is_bne && !equal) || is_j || is_jr);
  assign redir_now = taken && !stall;

  assign pc_id_plus4 = pc_id + 32'd4;
  assign br_offset   = {{14{imm16[15]}}, imm16, 2'b00};
  assign br_target   = pc_id_plus4 + br_offset;
  assign j_target    = {pc_id_plus4[31:28], instr_index, 2'b00};
  assign target      = is_jr ? rs_val : (is_j ? j_target : br_target);
  assign pc_seq      = pc_q + 32'd4;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= FETCH;
      pc_q          <= PC_RESET;
      req_q         <= 1'b0;
      pend_q        <= 1'b0;
      pend_target_q <= 32'd0;
    end else begin
      req_q <= 1'b1;
      case (state_q)
        FETCH: begin
          if (imem_ack && !stall) begin
            pc_q   <= redir_now ? target : pc_seq;
            pend_q <= 1'b0;
          end else if (!imem_ack && redir_now) begin
            // Delay-slot word not yet delivered: park the target until it is.
            pend_q        <= 1'b1;
            pend_target_q <= target;
            state_q       <= FETCH_PEND;
          end
        end
        FETCH_PEND: begin
          // A second redirect here cannot happen; the first target is kept.
          if (imem_ack && !stall) begin
            pc_q    <= pend_target_q;
            pend_q  <= 1'b0;
            state_q <= FETCH;
          end
        end
        default: begin
          state_q <= FETCH;
          pend_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef BR_STATS_EN
  logic        accepted;
  logic [31:0] br_cnt_q;
  logic [31:0] br_taken_cnt_q;

  assign accepted = id_valid && !stall && (is_beq || is_bne || is_j || is_jr);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      br_cnt_q       <= 32'd0;
      br_taken_cnt_q <= 32'd0;
    end else begin
      if (accepted) br_cnt_q <= br_cnt_q + 32'd1;
      if (redir_now) br_taken_cnt_q <= br_taken_cnt_q + 32'd1;
    end
  end

  assign br_cnt       = br_cnt_q;
  assign br_taken_cnt = br_taken_cnt_q;
`endif

  assign pc          = pc_q;
  assign imem_req    = req_q;
  assign fetch_valid = imem_ack;
  assign link_pc     = pc_id + 32'd8;
  assign state_dbg   = state_q;
  assign pend_dbg    = pend_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl: sequential fetch, branches, jumps, stalls,
// buffered redirects and reset during a pending redirect.
module tb_pc_fetch_ctrl;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        id_valid;
  logic        is_beq;
  logic        is_bne;
  logic        is_j;
  logic        is_jr;
  logic        equal;
  logic [31:0] pc_id;
  logic [15:0] imm16;
  logic [25:0] instr_index;
  logic [31:0] rs_val;
  logic        imem_ack;
  logic [31:0] pc;
  logic        imem_req;
  logic        fetch_valid;
  logic [31:0] link_pc;
`ifdef BR_STATS_EN
  logic [31:0] br_cnt;
  logic [31:0] br_taken_cnt;
`endif
  logic        state_dbg;
  logic        pend_dbg;

  int n_chk;
  int n_fail;

  pc_fetch_ctrl #(.PC_RESET(32'h0000_3000)) dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .id_valid    (id_valid),
    .is_beq      (is_beq),
    .is_bne      (is_bne),
    .is_j        (is_j),
    .is_jr       (is_jr),
    .equal       (equal),
    .pc_id       (pc_id),
    .imm16       (imm16),
    .instr_index (instr_index),
    .rs_val      (rs_val),
    .imem_ack    (imem_ack),
    .pc          (pc),
    .imem_req    (imem_req),
    .fetch_valid (fetch_valid),
    .link_pc     (link_pc),
`ifdef BR_STATS_EN
    .br_cnt      (br_cnt),
    .br_taken_cnt(br_taken_cnt),
`endif
    .state_dbg   (state_dbg),
    .pend_dbg    (pend_dbg)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // A redirect while one is already pending must never be presented.
  always @(posedge clk) begin
    if (reset) begin
      assert (!(pend_dbg && id_valid && !stall &&
                ((is_beq && equal) || (is_bne && !equal) || is_j || is_jr)))
        else $error("FAIL redirect_while_pend");
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_id();
    id_valid = 1'b0;
    is_beq   = 1'b0;
    is_bne   = 1'b0;
    is_j     = 1'b0;
    is_jr    = 1'b0;
    equal    = 1'b0;
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    reset = 1'b0;
    stall = 1'b0;
    clear_id();
    pc_id = 32'd0;
    imm16 = 16'd0;
    instr_index = 26'd0;
    rs_val = 32'd0;
    imem_ack = 1'b0;

    tick();
    tick();
    check("rst_pc", pc, 32'h0000_3000);
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_state", {31'd0, state_dbg}, 32'd0);
    check("rst_pend", {31'd0, pend_dbg}, 32'd0);

    @(negedge clk);
    reset = 1'b1;
    #1;
    check("req_before_edge", {31'd0, imem_req}, 32'd0);
    tick();
    check("req_after_release", {31'd0, imem_req}, 32'd1);

    // sequential fetch with ack every cycle
    imem_ack = 1'b1;
    #1;
    check("seq_pc0", pc, 32'h0000_3000);
    check("seq_fv0", {31'd0, fetch_valid}, 32'd1);
    tick();
    check("seq_pc1", pc, 32'h0000_3004);
    tick();
    check("seq_pc2", pc, 32'h0000_3008);

    // beq taken with ack in the same cycle: 0x3004 + 4 + (4 << 2)
    id_valid = 1'b1;
    is_beq = 1'b1;
    equal = 1'b1;
    pc_id = 32'h0000_3004;
    imm16 = 16'h0004;
    #1;
    check("beq_link", link_pc, 32'h0000_300c);
    tick();
    check("beq_pc", pc, 32'h0000_3018);

    // bne with equal=1 is not taken
    clear_id();
    id_valid = 1'b1;
    is_bne = 1'b1;
    equal = 1'b1;
    pc_id = 32'h0000_3010;
    tick();
    check("bne_nt_pc", pc, 32'h0000_301c);

    // jr without ack: buffered until the delay slot arrives
    clear_id();
    imem_ack = 1'b0;
    id_valid = 1'b1;
    is_jr = 1'b1;
    rs_val = 32'h0000_4100;
    tick();
    check("jr_state", {31'd0, state_dbg}, 32'd1);
    check("jr_pend", {31'd0, pend_dbg}, 32'd1);
    check("jr_hold0", pc, 32'h0000_301c);
    clear_id();
    tick();
    check("jr_hold1", pc, 32'h0000_301c);
    check("jr_state1", {31'd0, state_dbg}, 32'd1);
    imem_ack = 1'b1;
    tick();
    check("jr_pc", pc, 32'h0000_4100);
    check("jr_pend_clr", {31'd0, pend_dbg}, 32'd0);
    check("jr_state_clr", {31'd0, state_dbg}, 32'd0);

    // j under stall for 3 cycles, then applied
    stall = 1'b1;
    id_valid = 1'b1;
    is_j = 1'b1;
    pc_id = 32'h0000_3010;
    instr_index = 26'h000_1000;
    #1;
    check("j_link", link_pc, 32'h0000_3018);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_hold", pc, 32'h0000_4100);
    end
    stall = 1'b0;
    tick();
    check("j_pc", pc, 32'h0000_4000);
    clear_id();
    tick();
    check("post_j_seq", pc, 32'h0000_4004);

    // bne taken (equal=0) with negative offset: 0x4000 + 4 - 8
    id_valid = 1'b1;
    is_bne = 1'b1;
    equal = 1'b0;
    pc_id = 32'h0000_4000;
    imm16 = 16'hfffe;
    tick();
    check("bne_neg_pc", pc, 32'h0000_3ffc);
    clear_id();

    // buffer a beq redirect, then reset while it is pending
    imem_ack = 1'b0;
    id_valid = 1'b1;
    is_beq = 1'b1;
    equal = 1'b1;
    pc_id = 32'h0000_3004;
    imm16 = 16'h0004;
    tick();
    check("pend_set", {31'd0, pend_dbg}, 32'd1);
    clear_id();
`ifdef BR_STATS_EN
    check("br_cnt", br_cnt, 32'd6);
    check("br_taken_cnt", br_taken_cnt, 32'd5);
`endif
    #2;
    reset = 1'b0;
    #1;
    check("midrst_pc", pc, 32'h0000_3000);
    check("midrst_pend", {31'd0, pend_dbg}, 32'd0);
    check("midrst_state", {31'd0, state_dbg}, 32'd0);
    check("midrst_req", {31'd0, imem_req}, 32'd0);
`ifdef BR_STATS_EN
    check("midrst_br_cnt", br_cnt, 32'd0);
    check("midrst_br_taken", br_taken_cnt, 32'd0);
`endif
    imem_ack = 1'b1;
    tick();
    check("rst_ack_ignored", pc, 32'h0000_3000);

    @(negedge clk);
    imem_ack = 1'b0;
    reset = 1'b1;
    tick();
    check("rerel_pc", pc, 32'h0000_3000);
    check("rerel_req", {31'd0, imem_req}, 32'd1);
    imem_ack = 1'b1;
    tick();
    check("rerel_seq", pc, 32'h0000_3004);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
- Program-counter and fetch-control stage of the 5-stage MIPS pipeline.
- Consumes the branch comparator's `equal` result and ID-stage decode flags, and computes the redirect target (beq/bne/j/jal/jr/jalr).
- Owns the PC register and drives a req/ack handshake to instruction memory.
- Architectural branch delay slot. A redirect that arrives while the delay-slot fetch is still outstanding is buffered and applied once that fetch completes.

Parameters:
PC_RESET, 32'h0000_3000, PC value loaded on reset.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
stall  in  1  hazard-unit stall; IF/ID and PC hold when 1
id_valid  in  1  ID-stage instruction is valid
is_beq  in  1  ID instr is beq
is_bne  in  1  ID instr is bne
is_j  in  1  ID instr is j or jal
is_jr  in  1  ID instr is jr or jalr
equal  in  1  comparator result for the forwarded rs/rt of the ID instr
pc_id  in  32  PC of the ID-stage instruction
imm16  in  16  branch offset field
instr_index  in  26  jump index field
rs_val  in  32  forwarded rs value, used as the jr target
imem_ack  in  1  instruction memory returns data for `pc` this cycle
pc  out  32  current fetch address
imem_req  out  1  fetch request
fetch_valid  out  1  fetched word valid; IF/ID loads when fetch_valid && !stall
link_pc  out  32  pc_id + 8, the jal/jalr link value

Behaviour:
- Reset (reset=0, async):
  - pc=PC_RESET, pend=0, pend_target=0, state=FETCH.
  - imem_req=0 while in reset; the first req occurs on the first edge-free cycle after release.
- States:
  - FETCH: imem_req=1, waiting for ack.
  - FETCH_PEND: imem_req=1, a buffered redirect is outstanding.
- taken = id_valid && (is_beq&&equal || is_bne&&!equal || is_j || is_jr). At most one flag is set; more than one is illegal.
- redir_now = taken && !stall. A decision made under stall is ignored and re-evaluated next cycle.
- Targets, all 32-bit with wrap-around:
  - beq/bne: pc_id + 4 + (sign_ext(imm16) << 2).
  - j: {(pc_id+4)[31:28], instr_index, 2'b00}.
  - jr: rs_val, unmodified; no alignment check.
- fetch_valid = imem_ack, combinational.
- pc update at the clock edge:
  - imem_ack && !stall && redir_now → pc ← target; pend ← 0.
  - imem_ack && !stall && pend → pc ← pend_target; pend ← 0; state → FETCH.
  - imem_ack && !stall, otherwise → pc ← pc + 4.
  - imem_ack && stall → pc held; the same address is refetched next cycle.
  - !imem_ack && redir_now → pend ← 1, pend_target ← target, state → FETCH_PEND; pc held. The delay-slot fetch completes first.
  - !imem_ack, otherwise → hold.
- Priority: a redirect in the same cycle as an ack takes effect immediately. There is no pending entry, and the delay-slot word is the word delivered in that cycle.
- A redirect while pend=1 is impossible: a new ID instruction requires the delay slot to be delivered first. The bench asserts it never occurs. RTL keeps the first pend_target.
- Latency:
  - Redirect visible on `pc` one cycle after the redirect_now cycle with ack.
  - Otherwise visible on the cycle after the ack that completes the delay slot.
- link_pc = pc_id + 8, combinational.
- Reset mid-fetch (reset=0 during FETCH_PEND): pend cleared, pc=PC_RESET, and the outstanding ack is ignored.

Optional Feature:
BR_STATS_EN
- Defined:
  - Adds outputs br_cnt[31:0] and br_taken_cnt[31:0], both reset to 0.
  - br_cnt increments once per accepted branch/jump (id_valid && !stall && any flag).
  - br_taken_cnt increments on redir_now.
  - Both counters wrap at 2^32.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset release, imem_ack=1 every cycle, no branches → pc sequence 0x3000, 0x3004, 0x3008; fetch_valid=1 each cycle.
- beq with pc_id=0x3004, imm16=0x0004, equal=1, and ack in the same cycle → next pc=0x3018. bne with equal=1 → pc+4.
- jr with rs_val=0x0000_4100 while ack=0 for 2 cycles:
  - state=FETCH_PEND and pc held.
  - On ack, pc→0x4100 and pend cleared.
- stall=1 for 3 cycles with ack=1 and taken asserted → pc constant, no redirect; after stall drops, redirect applies.
- j with pc_id=0x3010, instr_index=0x0001000 → pc=0x0000_4000; link_pc=0x3018.
- reset asserted during FETCH_PEND → pc=0x3000 immediately (async), pend=0. With BR_STATS_EN, counters read 0.
